game_flow_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 36 +++
 rtl/game_flow_ctrl_load_down_counter.sv | 37 +++
 rtl/game_flow_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game-flow controller.
//   game_state_t  : 3-bit state encoding (INIT=0, PLAY=1, RESUME=2, CLEAR=3, OVER=4)
//   LEVEL_MAX     : level counter saturation value
//   ctrl_out_t    : Moore control outputs {sprite_reset, map_wr_reset, ghost_enable}
//   state_outputs : decodes a state into its Moore control outputs
package game_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    PLAY   = 3'd1,
    RESUME = 3'd2,
    CLEAR  = 3'd3,
    OVER   = 3'd4
  } game_state_t;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

  typedef struct packed {
    logic sprite_reset;
    logic map_wr_reset;
    logic ghost_enable;
  } ctrl_out_t;

  function automatic ctrl_out_t state_outputs(input game_state_t s);
    ctrl_out_t o;
    case (s)
      INIT:    o = ctrl_out_t'(3'b110);
      PLAY:    o = ctrl_out_t'(3'b001);
      RESUME:  o = ctrl_out_t'(3'b100);
      CLEAR:   o = ctrl_out_t'(3'b110);
      default: o = ctrl_out_t'(3'b010); // OVER
    endcase
    return o;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_load_down_counter.sv
// load_down_counter: loadable down-counter that stops at zero.
//   clk   : clock
//   srst  : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear (count -> 0), wins over load
//   load  : load MAX-1
//   en    : decrement while nonzero
//   count : current value, width W = max(1, $clog2(MAX))
//   zero  : count == 0
module load_down_counter #(
  parameter int MAX = 4,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= W'(MAX - 1);
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-flow state machine for the Pac-Man top level.
// Compares pacman against N_GHOSTS ghosts, tracks lives and levels, times the
// resume / level-clear pauses and (optionally) the power-pill frightened window.
// Optional feature macro: GAME_FRIGHT_EN (frightened window and ghost eating).
// Ports:
//   CLOCK_50, reset           : clock, synchronous active-high reset
//   start                     : leave INIT
//   pac_x/pac_y               : pacman next tile
//   ghost_x/ghost_y           : packed ghost next tiles, ghost i at [i*W +: W]
//   power_pill                : one-cycle pulse, pill eaten
//   dots_left                 : dots remaining on the map
//   state, lives, level       : game status
//   sprite_reset, map_wr_reset, ghost_enable : Moore control outputs
//   fright, ghost_eaten, death: frightened flag and one-cycle event pulses
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int N_GHOSTS      = 2,
  parameter int X_W           = 6,
  parameter int Y_W           = 5,
  parameter int LIVES_INIT    = 3,
  parameter int LIVES_W       = 3,
  parameter int RESUME_CYCLES = 250000000,
  parameter int FRIGHT_CYCLES = 350000000,
  parameter int DOTS_W        = 10
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic [X_W-1:0]          pac_x,
  input  logic [Y_W-1:0]          pac_y,
  input  logic [N_GHOSTS*X_W-1:0] ghost_x,
  input  logic [N_GHOSTS*Y_W-1:0] ghost_y,
  input  logic                    power_pill,
  input  logic [DOTS_W-1:0]       dots_left,
  output logic [2:0]              state,
  output logic [LIVES_W-1:0]      lives,
  output logic [3:0]              level,
  output logic                    sprite_reset,
  output logic                    map_wr_reset,
  output logic                    ghost_enable,
  output logic                    fright,
  output logic [N_GHOSTS-1:0]     ghost_eaten,
  output logic                    death
);

  localparam int PAUSE_W = (RESUME_CYCLES > 1) ? $clog2(RESUME_CYCLES) : 1;

  game_state_t          state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [3:0]           level_q, level_d;
  logic                 death_q, death_d;
  ctrl_out_t            ctrl_q;

  logic [N_GHOSTS-1:0]  match, hit, eaten_mask;
  logic                 fright_act;
  logic                 dots_empty, fatal_hit, enter_pause;
  logic                 pause_zero;
  logic [PAUSE_W-1:0]   pause_count_unused;

  genvar gi;
  generate
    for (gi = 0; gi < N_GHOSTS; gi++) begin : g_cmp
      assign match[gi] = (ghost_x[gi*X_W +: X_W] == pac_x) &&
                         (ghost_y[gi*Y_W +: Y_W] == pac_y);
    end
  endgenerate

  // Ghosts already eaten in this window are passed through harmlessly.
  assign hit         = match & ~eaten_mask;
  assign dots_empty  = (dots_left == '0);
  // Uses the registered fright flag, so a pill arriving with a collision
  // does not save pacman.
  assign fatal_hit   = !fright_act && (|hit);
  assign enter_pause = (state_q == PLAY) && (dots_empty || fatal_hit);

  load_down_counter #(.MAX(RESUME_CYCLES), .W(PAUSE_W)) u_pause_cnt (
    .clk   (CLOCK_50),
    .srst  (reset),
    .clr   (1'b0),
    .load  (enter_pause),
    .en    ((state_q == RESUME) || (state_q == CLEAR)),
    .count (pause_count_unused),
    .zero  (pause_zero)
  );

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    death_d = 1'b0;
    case (state_q)
      INIT: if (start) state_d = PLAY;
      PLAY: begin
        if (dots_empty) begin
          state_d = CLEAR;
        end else if (fatal_hit) begin
          death_d = 1'b1;
          if (lives_q > LIVES_W'(1)) begin
            state_d = RESUME;
            lives_d = lives_q - LIVES_W'(1);
          end else begin
            state_d = OVER;
            lives_d = '0;
          end
        end
      end
      RESUME: if (pause_zero) state_d = PLAY;
      CLEAR: begin
        if (pause_zero) begin
          state_d = PLAY;
          if (level_q != LEVEL_MAX) level_d = level_q + 4'd1;
        end
      end
      default: ; // OVER holds until reset
    endcase
  end

  // Control outputs are decoded from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= INIT;
      lives_q <= LIVES_W'(LIVES_INIT);
      level_q <= '0;
      death_q <= 1'b0;
      ctrl_q  <= state_outputs(INIT);
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      death_q <= death_d;
      ctrl_q  <= state_outputs(state_d);
    end
  end

`ifdef GAME_FRIGHT_EN
  localparam int FRIGHT_W = (FRIGHT_CYCLES > 1) ? $clog2(FRIGHT_CYCLES) : 1;

  logic                fright_q;
  logic [N_GHOSTS-1:0] mask_q, eaten_q;
  logic                in_play, leave_play, fright_zero;
  logic [FRIGHT_W-1:0] fright_count_unused;

  assign in_play    = (state_q == PLAY);
  assign leave_play = enter_pause;

  load_down_counter #(.MAX(FRIGHT_CYCLES), .W(FRIGHT_W)) u_fright_cnt (
    .clk   (CLOCK_50),
    .srst  (reset),
    .clr   (!in_play || leave_play),
    .load  (power_pill),
    .en    (fright_q),
    .count (fright_count_unused),
    .zero  (fright_zero)
  );

  // Staying in PLAY implies any remaining hit happened under fright, so the
  // hit vector can be latched into the mask and pulsed directly.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fright_q <= 1'b0;
      mask_q   <= '0;
      eaten_q  <= '0;
    end else begin
      eaten_q <= '0;
      if (!in_play || leave_play) begin
        fright_q <= 1'b0;
        mask_q   <= '0;
      end else begin
        eaten_q <= hit;
        if (power_pill) begin
          fright_q <= 1'b1;
          mask_q   <= mask_q | hit;
        end else if (fright_q && fright_zero) begin
          fright_q <= 1'b0;
          mask_q   <= '0;
        end else begin
          mask_q   <= mask_q | hit;
        end
      end
    end
  end

  assign fright_act  = fright_q;
  assign eaten_mask  = mask_q;
  assign ghost_eaten = eaten_q;
`else
  logic power_pill_unused;
  assign power_pill_unused = power_pill;
  assign fright_act        = 1'b0;
  assign eaten_mask        = '0;
  assign ghost_eaten       = '0;
`endif

  assign state        = state_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign death        = death_q;
  assign fright       = fright_act;
  assign sprite_reset = ctrl_q.sprite_reset;
  assign map_wr_reset = ctrl_q.map_wr_reset;
  assign ghost_enable = ctrl_q.ghost_enable;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with N_GHOSTS=3, RESUME_CYCLES=4,
// FRIGHT_CYCLES=8, LIVES_INIT=3. Fright scenarios depend on GAME_FRIGHT_EN.
module tb_game_flow_ctrl;
  localparam int NG = 3, XW = 6, YW = 5, LW = 3, DW = 10;
  localparam logic [2:0] S_INIT = 3'd0, S_PLAY = 3'd1, S_RESUME = 3'd2,
                         S_CLEAR = 3'd3, S_OVER = 3'd4;
  localparam logic [2:0] M_INIT = 3'b110, M_PLAY = 3'b001, M_RESUME = 3'b100,
                         M_CLEAR = 3'b110, M_OVER = 3'b010;
  localparam logic [XW-1:0] PX = 6'd10;
  localparam logic [YW-1:0] PY = 5'd10;

  logic CLOCK_50 = 1'b0;
  logic reset, start, power_pill;
  logic [XW-1:0] pac_x;
  logic [YW-1:0] pac_y;
  logic [NG*XW-1:0] ghost_x;
  logic [NG*YW-1:0] ghost_y;
  logic [DW-1:0] dots_left;
  logic [2:0] state;
  logic [LW-1:0] lives;
  logic [3:0] level;
  logic sprite_reset, map_wr_reset, ghost_enable, fright, death;
  logic [NG-1:0] ghost_eaten;
  logic [2:0] moore;

  int checks = 0;
  int failures = 0;

  game_flow_ctrl #(
    .N_GHOSTS(NG), .X_W(XW), .Y_W(YW), .LIVES_INIT(3), .LIVES_W(LW),
    .RESUME_CYCLES(4), .FRIGHT_CYCLES(8), .DOTS_W(DW)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .power_pill(power_pill), .dots_left(dots_left),
    .state(state), .lives(lives), .level(level),
    .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
    .ghost_enable(ghost_enable), .fright(fright),
    .ghost_eaten(ghost_eaten), .death(death)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  assign moore = {sprite_reset, map_wr_reset, ghost_enable};

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic place_ghost(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y);
    ghost_x[i*XW +: XW] = x;
    ghost_y[i*YW +: YW] = y;
  endtask

  task automatic ghosts_away();
    place_ghost(0, 6'd0, 5'd0);
    place_ghost(1, 6'd1, 5'd1);
    place_ghost(2, 6'd2, 5'd2);
  endtask

  task automatic reset_and_start();
    reset = 1'b1; start = 1'b0; power_pill = 1'b0; dots_left = 10'd100;
    ghosts_away();
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Remaining pause cycles after the entry edge, then back to PLAY.
  task automatic wait_pause(input logic [2:0] st, input logic [3:0] lvl_after);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (state !== st) begin
        failures++; $display("FAIL pause_hold k=%0d state=%0d exp=%0d", k, state, st);
      end
    end
    tick();
    checks++;
    if ({state, level} !== {S_PLAY, lvl_after}) begin
      failures++;
      $display("FAIL pause_exit state=%0d level=%0d exp state=%0d level=%0d", state, level, S_PLAY, lvl_after);
    end
  endtask

  task automatic kill(input int g, input logic [LW-1:0] exp_lives, input logic [2:0] exp_state,
                      input logic [2:0] exp_moore);
    place_ghost(g, PX, PY);
    tick();
    ghosts_away();
    checks++;
    if ({death, lives, state, moore} !== {1'b1, exp_lives, exp_state, exp_moore}) begin
      failures++;
      $display("FAIL kill_g%0d death=%0b lives=%0d state=%0d moore=%b exp 1/%0d/%0d/%b",
               g, death, lives, state, moore, exp_lives, exp_state, exp_moore);
    end
    $display("death: ghost %0d lives=%0d state=%0d", g, lives, state);
    if (exp_state == S_RESUME) begin
      wait_pause(S_RESUME, 4'd0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; power_pill = 1'b0; dots_left = 10'd100;
    pac_x = PX; pac_y = PY;
    ghosts_away();
    tick();
    checks++;
    if ({state, lives, level, fright, ghost_eaten, death, moore} !==
        {S_INIT, 3'd3, 4'd0, 1'b0, 3'b000, 1'b0, M_INIT}) begin
      failures++;
      $display("FAIL reset_values state=%0d lives=%0d level=%0d fright=%0b eaten=%b death=%0b moore=%b",
               state, lives, level, fright, ghost_eaten, death, moore);
    end
    reset = 1'b0; start = 1'b0;
    tick();
    checks++;
    if ({state, moore} !== {S_INIT, M_INIT}) begin
      failures++; $display("FAIL init_hold state=%0d moore=%b exp %0d/%b", state, moore, S_INIT, M_INIT);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({state, moore} !== {S_PLAY, M_PLAY}) begin
      failures++; $display("FAIL start_play state=%0d moore=%b exp %0d/%b", state, moore, S_PLAY, M_PLAY);
    end
    $display("reset/start: state=%0d moore=%b", state, moore);
  endtask

  task automatic test_deaths();
    reset_and_start();
    kill(2, 3'd2, S_RESUME, M_RESUME);
    kill(2, 3'd1, S_RESUME, M_RESUME);
    kill(2, 3'd0, S_OVER, M_OVER);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({state, moore, death, lives} !== {S_OVER, M_OVER, 1'b0, 3'd0}) begin
        failures++;
        $display("FAIL over_hold k=%0d state=%0d moore=%b death=%0b lives=%0d", k, state, moore, death, lives);
      end
    end
    start = 1'b0;
  endtask

`ifdef GAME_FRIGHT_EN
  task automatic test_fright_eat();
    reset_and_start();
    power_pill = 1'b1;
    tick();                       // t=0
    power_pill = 1'b0;
    checks++;
    if (fright !== 1'b1) begin failures++; $display("FAIL fright_on got=%0b exp=1", fright); end
    place_ghost(0, PX, PY);
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if ({ghost_eaten, death, lives, state} !== {((t == 1) ? 3'b001 : 3'b000), 1'b0, 3'd3, S_PLAY}) begin
        failures++;
        $display("FAIL eat_t%0d eaten=%b death=%0b lives=%0d state=%0d", t, ghost_eaten, death, lives, state);
      end
      $display("eat: t=%0d ghost_eaten=%b", t, ghost_eaten);
    end
    ghosts_away();
    for (int t = 4; t <= 7; t++) begin
      tick();
      checks++;
      if (fright !== 1'b1) begin failures++; $display("FAIL fright_window t=%0d got=%0b exp=1", t, fright); end
    end
    tick();                       // t=8
    checks++;
    if (fright !== 1'b0) begin failures++; $display("FAIL fright_expire got=%0b exp=0", fright); end
    kill(0, 3'd2, S_RESUME, M_RESUME);
  endtask

  task automatic test_pill_collision();
    reset_and_start();
    power_pill = 1'b1;
    place_ghost(1, PX, PY);
    tick();
    power_pill = 1'b0;
    ghosts_away();
    checks++;
    if ({death, ghost_eaten, fright, lives, state} !== {1'b1, 3'b000, 1'b0, 3'd2, S_RESUME}) begin
      failures++;
      $display("FAIL pill_collide death=%0b eaten=%b fright=%0b lives=%0d state=%0d",
               death, ghost_eaten, fright, lives, state);
    end
    wait_pause(S_RESUME, 4'd0);
    power_pill = 1'b1;
    tick();                       // t=0
    power_pill = 1'b0;
    for (int t = 1; t <= 4; t++) tick();
    power_pill = 1'b1;
    tick();                       // t=5 reload
    power_pill = 1'b0;
    for (int t = 6; t <= 12; t++) begin
      tick();
      checks++;
      if (fright !== 1'b1) begin failures++; $display("FAIL reload_window t=%0d got=%0b exp=1", t, fright); end
    end
    tick();                       // t=13
    checks++;
    if (fright !== 1'b0) begin failures++; $display("FAIL reload_expire got=%0b exp=0", fright); end
    $display("reload: fright=%0b after 8 cycles from second pill", fright);
  endtask

  task automatic test_reset_mid_fright();
    reset_and_start();
    power_pill = 1'b1;
    tick();
    power_pill = 1'b0;
    place_ghost(0, PX, PY);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({state, fright, ghost_eaten, death, lives} !== {S_INIT, 1'b0, 3'b000, 1'b0, 3'd3}) begin
      failures++;
      $display("FAIL reset_mid_fright state=%0d fright=%0b eaten=%b death=%0b lives=%0d",
               state, fright, ghost_eaten, death, lives);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();                       // ghost 0 still overlapping, mask must be clear
    ghosts_away();
    checks++;
    if ({death, lives, state} !== {1'b1, 3'd2, S_RESUME}) begin
      failures++;
      $display("FAIL mask_cleared death=%0b lives=%0d state=%0d", death, lives, state);
    end
  endtask
`else
  task automatic test_fright_disabled();
    reset_and_start();
    power_pill = 1'b1;
    place_ghost(0, PX, PY);
    tick();
    power_pill = 1'b0;
    ghosts_away();
    checks++;
    if ({fright, ghost_eaten, death, lives, state} !== {1'b0, 3'b000, 1'b1, 3'd2, S_RESUME}) begin
      failures++;
      $display("FAIL nofright_pill fright=%0b eaten=%b death=%0b lives=%0d state=%0d",
               fright, ghost_eaten, death, lives, state);
    end
    wait_pause(S_RESUME, 4'd0);
    power_pill = 1'b1;
    tick();
    power_pill = 1'b0;
    checks++;
    if (fright !== 1'b0) begin failures++; $display("FAIL nofright_flag got=%0b exp=0", fright); end
    kill(1, 3'd1, S_RESUME, M_RESUME);
  endtask
`endif

  task automatic test_clear();
    logic [3:0] exp_lvl;
    reset_and_start();
    dots_left = 10'd0;
    place_ghost(0, PX, PY);
    tick();
    dots_left = 10'd100;
    ghosts_away();
    checks++;
    if ({state, death, lives, level, moore} !== {S_CLEAR, 1'b0, 3'd3, 4'd0, M_CLEAR}) begin
      failures++;
      $display("FAIL clear_entry state=%0d death=%0b lives=%0d level=%0d moore=%b",
               state, death, lives, level, moore);
    end
    wait_pause(S_CLEAR, 4'd1);
    for (int k = 2; k <= 16; k++) begin
      exp_lvl = (k > 15) ? 4'd15 : 4'(k);
      dots_left = 10'd0;
      tick();
      dots_left = 10'd100;
      checks++;
      if (state !== S_CLEAR) begin failures++; $display("FAIL clear_k%0d state=%0d exp=%0d", k, state, S_CLEAR); end
      wait_pause(S_CLEAR, exp_lvl);
      $display("clear %0d: level=%0d", k, level);
    end
  endtask

  task automatic test_reset_mid_resume();
    reset_and_start();
    dots_left = 10'd0;
    tick();
    dots_left = 10'd100;
    wait_pause(S_CLEAR, 4'd1);
    place_ghost(2, PX, PY);
    tick();
    ghosts_away();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({state, lives, level, fright, ghost_eaten, death, moore} !==
        {S_INIT, 3'd3, 4'd0, 1'b0, 3'b000, 1'b0, M_INIT}) begin
      failures++;
      $display("FAIL reset_mid_resume state=%0d lives=%0d level=%0d fright=%0b eaten=%b death=%0b moore=%b",
               state, lives, level, fright, ghost_eaten, death, moore);
    end
    $display("reset mid-resume: state=%0d lives=%0d level=%0d", state, lives, level);
  endtask

  initial begin
    test_reset();
    test_deaths();
`ifdef GAME_FRIGHT_EN
    test_fright_eat();
    test_pill_collision();
    test_reset_mid_fright();
`else
    test_fright_disabled();
`endif
    test_clear();
    test_reset_mid_resume();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
